unidade_busca: RTL and testbench

UNIDADE_BUSCA -- requirements
Module: unidade_busca

---
 rtl/unidade_busca_pkg.sv | 19 +
 rtl/unidade_busca_if.sv | 33 +++
 rtl/unidade_busca_fila.sv | 90 +++++++++
 rtl/unidade_busca.sv | 110 +++++++++++
 tb/tb_unidade_busca.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the instruction fetch unit (unidade_busca).
// Contents: FSM state type, HALT opcode, fetch FIFO depth and the
// occupancy counter width derived from it, plus a halt-opcode helper.
package unidade_busca_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } estado_t;

    localparam logic [5:0] OPCODE_HALT       = 6'b111111;
    localparam int         FILA_PROFUNDIDADE = 2;
    localparam int         OCUP_W            = $clog2(FILA_PROFUNDIDADE + 1);

    function automatic logic eh_halt(input logic [5:0] opcode);
        return opcode == OPCODE_HALT;
    endfunction

endpackage

// File: rtl/unidade_busca_if.sv
// Bus between the fetch unit, the synchronous instruction ROM and the
// instruction consumer.
//   pc_mem          ROM address (registered in the fetch unit)
//   instrucao_mem   ROM word for the address seen at the previous edge
//   desvio          redirect request, endereco_desvio its target
//   parada          consumer stall (head word not accepted)
//   instrucao       head word, pc_instrucao its address, valida head valid
//   parado          fetch unit halted
// master = fetch unit side, slave = ROM/consumer side.
interface unidade_busca_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] pc_mem;
    logic [DATA_WIDTH-1:0] instrucao_mem;
    logic                  desvio;
    logic [ADDR_WIDTH-1:0] endereco_desvio;
    logic                  parada;
    logic [DATA_WIDTH-1:0] instrucao;
    logic [ADDR_WIDTH-1:0] pc_instrucao;
    logic                  valida;
    logic                  parado;

    modport master (
        output pc_mem, instrucao, pc_instrucao, valida, parado,
        input  instrucao_mem, desvio, endereco_desvio, parada
    );

    modport slave (
        input  pc_mem, instrucao, pc_instrucao, valida, parado,
        output instrucao_mem, desvio, endereco_desvio, parada
    );
endinterface

// File: rtl/unidade_busca_fila.sv
// fila_busca: 2-entry FIFO of {word, address} for the fetch unit.
// Entry 0 is always the head, so the outputs come straight from registers.
// Ports: clk_i, rst_i (async, active high), push_i/word_i/addr_i,
// pop_i, clear_i (wins over push/pop), ocupacao_o, head_word_o, head_addr_o.
module fila_busca
    import unidade_busca_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [OCUP_W-1:0]     ocupacao_o,
    output logic [DATA_WIDTH-1:0] head_word_o,
    output logic [ADDR_WIDTH-1:0] head_addr_o
);
    logic [DATA_WIDTH-1:0] word_q [FILA_PROFUNDIDADE];
    logic [DATA_WIDTH-1:0] word_d [FILA_PROFUNDIDADE];
    logic [ADDR_WIDTH-1:0] addr_q [FILA_PROFUNDIDADE];
    logic [ADDR_WIDTH-1:0] addr_d [FILA_PROFUNDIDADE];
    logic [OCUP_W-1:0]     ocup_q, ocup_d;
    logic                  pop_ef;

    assign pop_ef = pop_i && (ocup_q != '0);

    always_comb begin
        word_d = word_q;
        addr_d = addr_q;
        ocup_d = ocup_q;
        if (clear_i) begin
            ocup_d = '0;
        end else begin
            case ({push_i, pop_ef})
                2'b10: begin
                    if (ocup_q == '0) begin
                        word_d[0] = word_i;
                        addr_d[0] = addr_i;
                    end else begin
                        word_d[1] = word_i;
                        addr_d[1] = addr_i;
                    end
                    ocup_d = ocup_q + 1'b1;
                end
                2'b01: begin
                    word_d[0] = word_q[1];
                    addr_d[0] = addr_q[1];
                    ocup_d    = ocup_q - 1'b1;
                end
                2'b11: begin
                    // Simultaneous push/pop: the new word lands right behind
                    // whatever survives the pop.
                    if (ocup_q == OCUP_W'(1)) begin
                        word_d[0] = word_i;
                        addr_d[0] = addr_i;
                    end else begin
                        word_d[0] = word_q[1];
                        addr_d[0] = addr_q[1];
                        word_d[1] = word_i;
                        addr_d[1] = addr_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ocup_q    <= '0;
            word_q[0] <= '0;
            word_q[1] <= '0;
            addr_q[0] <= '0;
            addr_q[1] <= '0;
        end else begin
            ocup_q <= ocup_d;
            word_q <= word_d;
            addr_q <= addr_d;
        end
    end

    assign ocupacao_o  = ocup_q;
    assign head_word_o = word_q[0];
    assign head_addr_o = addr_q[0];

endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch unit in front of a synchronous ROM.
// Issues one address per cycle while the buffer has room, pushes each ROM
// response into a 2-entry FIFO, delivers the FIFO head through a
// valid/stall handshake, and supports redirects and a HALT opcode.
// Ports: clk_i, rst_i (async, active high), bus (unidade_busca_if.master).
//
// state | meaning
// FETCH | issuing sequential addresses, pushing ROM responses
// HALT  | halt word seen; no issues, in-flight word dropped, FIFO drains
module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    unidade_busca_if.master   bus
);
    localparam int CW = OCUP_W + 1;

    estado_t               estado_q, estado_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  voo_q, voo_d;
    logic [ADDR_WIDTH-1:0] voo_addr_q, voo_addr_d;

    logic [OCUP_W-1:0]     ocupacao;
    logic [DATA_WIDTH-1:0] head_word;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic                  valida, pop, push, emite, halt_push, buscando, parado;
    logic [CW-1:0]         carga;

    assign valida = (ocupacao != '0);
    assign pop    = valida && !bus.parada;

    // Slots already committed after this edge; issue only if one stays free.
    assign carga  = {1'b0, ocupacao} + CW'(voo_q) - CW'(pop);
    assign emite  = buscando && !bus.desvio && (carga < CW'(FILA_PROFUNDIDADE));

    // In HALT the in-flight response is discarded rather than pushed.
    assign push      = voo_q && buscando && !bus.desvio;
    assign halt_push = push && eh_halt(bus.instrucao_mem[DATA_WIDTH-1 -: 6]);

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) estado_q <= FETCH;
        else       estado_q <= estado_d;
    end

    // FSM: next state (redirect beats a simultaneous halt push)
    always_comb begin
        estado_d = estado_q;
        if (bus.desvio)     estado_d = FETCH;
        else if (halt_push) estado_d = HALT;
    end

    // FSM: outputs
    always_comb begin
        buscando = (estado_q == FETCH);
        parado   = (estado_q == HALT);
    end

    always_comb begin
        pc_d       = pc_q;
        voo_d      = 1'b0;
        voo_addr_d = voo_addr_q;
        if (bus.desvio) begin
            pc_d = bus.endereco_desvio;
        end else if (emite) begin
            voo_d      = 1'b1;
            voo_addr_d = pc_q;
            pc_d       = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= '0;
            voo_q      <= 1'b0;
            voo_addr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            voo_q      <= voo_d;
            voo_addr_q <= voo_addr_d;
        end
    end

    fila_busca #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fila (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .pop_i       (pop),
        .clear_i     (bus.desvio),
        .word_i      (bus.instrucao_mem),
        .addr_i      (voo_addr_q),
        .ocupacao_o  (ocupacao),
        .head_word_o (head_word),
        .head_addr_o (head_addr)
    );

    assign bus.pc_mem       = pc_q;
    assign bus.instrucao    = head_word;
    assign bus.pc_instrucao = head_addr;
    assign bus.valida       = valida;
    assign bus.parado       = parado;

endmodule

// File: tb/tb_unidade_busca.sv
// Testbench for unidade_busca: directed scenarios plus a randomized run
// checked against a program-order reference model of the delivered stream.
module tb_unidade_busca;

    localparam int DW = 32;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [DW-1:0] rom [256];

    unidade_busca_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    unidade_busca #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model
    always @(posedge clk) bus.instrucao_mem <= rom[bus.pc_mem];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rom_linear();
        for (int i = 0; i < 256; i++) rom[i] = 32'h100 + i;
    endtask

    // Leaves the bench at a negedge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.desvio = 1'b0;
        bus.parada = 1'b0;
        bus.endereco_desvio = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.pc_mem !== 8'h00 || bus.valida !== 1'b0 || bus.parado !== 1'b0 ||
            bus.instrucao !== 32'h0 || bus.pc_instrucao !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: pc_mem=%h valida=%b parado=%b instr=%h pc_instr=%h, required all zero",
                     bus.pc_mem, bus.valida, bus.parado, bus.instrucao, bus.pc_instrucao);
        end
    endtask

    task automatic test_sequencial();
        rom_linear();
        do_reset();
        tick();
        checks++;
        if (bus.valida !== 1'b0 || bus.pc_mem !== 8'h01) begin
            errors++;
            $display("FAIL seq_first_edge: valida=%b pc_mem=%h, required valida=0 pc_mem=01",
                     bus.valida, bus.pc_mem);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (bus.valida !== 1'b1 || bus.pc_instrucao !== 8'(k) || bus.instrucao !== 32'h100 + k) begin
                errors++;
                $display("FAIL seq_word%0d: valida=%b pc=%h instr=%h, required 1 %h %h",
                         k, bus.valida, bus.pc_instrucao, bus.instrucao, 8'(k), 32'h100 + k);
            end
        end
    endtask

    task automatic test_parada();
        int n;
        rom_linear();
        do_reset();
        n = 0;
        while (n < 20 && !(bus.valida === 1'b1 && bus.pc_instrucao === 8'h03)) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20 || bus.pc_mem !== 8'h05) begin
            errors++;
            $display("FAIL stall_reach_pc3: waited=%0d pc_mem=%h, required head 03 pc_mem=05", n, bus.pc_mem);
        end
        bus.parada = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus.valida !== 1'b1 || bus.pc_instrucao !== 8'h03 || bus.instrucao !== 32'h103 ||
                bus.pc_mem !== 8'h05) begin
                errors++;
                $display("FAIL stall_hold%0d: valida=%b pc=%h instr=%h pc_mem=%h, required 1 03 103 05",
                         c, bus.valida, bus.pc_instrucao, bus.instrucao, bus.pc_mem);
            end
        end
        bus.parada = 1'b0;
        for (int k = 4; k <= 6; k++) begin
            tick();
            checks++;
            if (bus.valida !== 1'b1 || bus.pc_instrucao !== 8'(k) || bus.instrucao !== 32'h100 + k) begin
                errors++;
                $display("FAIL stall_release_pc%0d: valida=%b pc=%h instr=%h",
                         k, bus.valida, bus.pc_instrucao, bus.instrucao);
            end
        end
    endtask

    task automatic test_desvio();
        int n;
        rom_linear();
        do_reset();
        n = 0;
        while (n < 20 && !(bus.valida === 1'b1 && bus.pc_instrucao === 8'h07)) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL branch_reach_pc7: head never reached 07");
        end
        bus.desvio = 1'b1;
        bus.endereco_desvio = 8'h40;
        tick();
        bus.desvio = 1'b0;
        checks++;
        if (bus.valida !== 1'b0 || bus.pc_mem !== 8'h40) begin
            errors++;
            $display("FAIL branch_flush: valida=%b pc_mem=%h, required 0 40", bus.valida, bus.pc_mem);
        end
        tick();
        checks++;
        if (bus.valida !== 1'b0) begin
            errors++;
            $display("FAIL branch_latency: valida=%b one edge after redirect, required 0", bus.valida);
        end
        for (int k = 8'h40; k <= 8'h41; k++) begin
            tick();
            checks++;
            if (bus.valida !== 1'b1 || bus.pc_instrucao !== 8'(k) || bus.instrucao !== 32'h100 + k) begin
                errors++;
                $display("FAIL branch_target_%h: valida=%b pc=%h instr=%h",
                         8'(k), bus.valida, bus.pc_instrucao, bus.instrucao);
            end
        end
    endtask

    task automatic test_halt();
        int n;
        rom_linear();
        rom[5] = 32'hFC00_0000;
        do_reset();
        n = 0;
        while (n < 20 && !(bus.valida === 1'b1 && bus.pc_instrucao === 8'h05)) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20 || bus.instrucao !== 32'hFC00_0000 || bus.parado !== 1'b1) begin
            errors++;
            $display("FAIL halt_word: waited=%0d instr=%h parado=%b, required FC000000 1",
                     n, bus.instrucao, bus.parado);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus.valida !== 1'b0 || bus.parado !== 1'b1) begin
                errors++;
                $display("FAIL halt_idle%0d: valida=%b parado=%b pc=%h, required 0 1",
                         c, bus.valida, bus.parado, bus.pc_instrucao);
            end
        end
        bus.desvio = 1'b1;
        bus.endereco_desvio = 8'h10;
        tick();
        bus.desvio = 1'b0;
        checks++;
        if (bus.parado !== 1'b0) begin
            errors++;
            $display("FAIL halt_exit: parado=%b, required 0", bus.parado);
        end
        tick();
        tick();
        checks++;
        if (bus.valida !== 1'b1 || bus.pc_instrucao !== 8'h10 || bus.instrucao !== 32'h110) begin
            errors++;
            $display("FAIL halt_resume: valida=%b pc=%h instr=%h, required 1 10 110",
                     bus.valida, bus.pc_instrucao, bus.instrucao);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [4];
        int idx;
        int n;
        seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        rom_linear();
        do_reset();
        bus.desvio = 1'b1;
        bus.endereco_desvio = 8'hFE;
        tick();
        bus.desvio = 1'b0;
        idx = 0;
        n = 0;
        while (n < 12 && idx < 4) begin
            tick();
            n++;
            if (bus.valida === 1'b1) begin
                checks++;
                if (bus.pc_instrucao !== seq[idx] || bus.instrucao !== 32'h100 + seq[idx] ||
                    (idx == 0 && n != 2)) begin
                    errors++;
                    $display("FAIL wrap_word%0d: pc=%h instr=%h edge=%0d, required %h %h",
                             idx, bus.pc_instrucao, bus.instrucao, n, seq[idx], 32'h100 + seq[idx]);
                end
                idx++;
            end
        end
        checks++;
        if (idx < 4) begin
            errors++;
            $display("FAIL wrap_timeout: delivered %0d of 4", idx);
        end
    endtask

    task automatic test_reset_mid();
        rom_linear();
        do_reset();
        repeat (4) tick();
        bus.parada = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.valida !== 1'b1 || bus.pc_instrucao !== 8'h02) begin
            errors++;
            $display("FAIL rmid_buffered: valida=%b pc=%h, required 1 02", bus.valida, bus.pc_instrucao);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.valida !== 1'b0 || bus.pc_mem !== 8'h00 || bus.pc_instrucao !== 8'h00 ||
            bus.instrucao !== 32'h0 || bus.parado !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: valida=%b pc_mem=%h pc=%h instr=%h parado=%b, required all zero",
                     bus.valida, bus.pc_mem, bus.pc_instrucao, bus.instrucao, bus.parado);
        end
        @(negedge clk);
        bus.parada = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (bus.valida !== 1'b0 || bus.pc_mem !== 8'h01) begin
            errors++;
            $display("FAIL rmid_first_issue: valida=%b pc_mem=%h, required 0 01", bus.valida, bus.pc_mem);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (bus.valida !== 1'b1 || bus.pc_instrucao !== 8'(k) || bus.instrucao !== 32'h100 + k) begin
                errors++;
                $display("FAIL rmid_restart%0d: valida=%b pc=%h instr=%h",
                         k, bus.valida, bus.pc_instrucao, bus.instrucao);
            end
        end
    endtask

    // Reference model: the delivered stream is program order starting at the
    // last redirect target, ending (inclusive) at the first halt word.
    task automatic test_aleatorio();
        logic [7:0]  exp_pc;
        logic [7:0]  prev_pc;
        logic [31:0] prev_instr;
        logic [31:0] w;
        bit fim, stalled_prev, d, p;
        int idle;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if ($urandom_range(0, 39) == 0) w[31:26] = 6'h3f;
            else                            w[31] = 1'b0;
            rom[i] = w;
        end
        do_reset();
        exp_pc = 8'h00;
        fim = 1'b0;
        stalled_prev = 1'b0;
        idle = 0;
        prev_pc = '0;
        prev_instr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (stalled_prev) begin
                checks++;
                if (bus.valida !== 1'b1 || bus.pc_instrucao !== prev_pc || bus.instrucao !== prev_instr) begin
                    errors++;
                    $display("FAIL rnd_stall_hold c%0d: valida=%b pc=%h instr=%h, required 1 %h %h",
                             cyc, bus.valida, bus.pc_instrucao, bus.instrucao, prev_pc, prev_instr);
                end
            end
            if (fim) begin
                checks++;
                if (bus.valida !== 1'b0 || bus.parado !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd_halted c%0d: valida=%b parado=%b, required 0 1",
                             cyc, bus.valida, bus.parado);
                end
            end else begin
                if (bus.valida === 1'b1) idle = 0;
                else                     idle++;
                checks++;
                if (idle > 3) begin
                    errors++;
                    $display("FAIL rnd_starved c%0d: valida low for %0d cycles", cyc, idle);
                    idle = 0;
                end
            end

            d = fim ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            p = ($urandom_range(0, 2) == 0);

            if (!d && !p && bus.valida === 1'b1) begin
                checks++;
                if (bus.pc_instrucao !== exp_pc || bus.instrucao !== rom[exp_pc]) begin
                    errors++;
                    $display("FAIL rnd_pop c%0d: pc=%h instr=%h, required %h %h",
                             cyc, bus.pc_instrucao, bus.instrucao, exp_pc, rom[exp_pc]);
                end
                if (rom[exp_pc][31:26] == 6'h3f) fim = 1'b1;
                exp_pc = exp_pc + 8'h01;
            end

            bus.desvio = d;
            bus.parada = p;
            bus.endereco_desvio = 8'($urandom);
            if (d) begin
                exp_pc = bus.endereco_desvio;
                fim = 1'b0;
                idle = 0;
            end
            stalled_prev = !d && p && (bus.valida === 1'b1);
            prev_pc = bus.pc_instrucao;
            prev_instr = bus.instrucao;
            tick();
        end
        bus.desvio = 1'b0;
        bus.parada = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.desvio = 1'b0;
        bus.parada = 1'b0;
        bus.endereco_desvio = '0;
        rom_linear();
        test_reset();
        test_sequencial();
        test_parada();
        test_desvio();
        test_halt();
        test_wrap();
        test_reset_mid();
        test_aleatorio();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
